// File: rtl/if_fetch_queue_pkg.sv
// Shared widths, constants and the {pc,inst} entry type for the IF-stage fetch queue.
package if_fetch_queue_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam int FETCH_Q_DEPTH = 4;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: PC-stage inputs, instruction-memory port and the IF/ID valid/ready head.
interface if_fetch_queue_if
  import if_fetch_queue_pkg::*;
#(
  parameter int CNT_W = 3
) ();

  logic                   ce;
  logic [INST_ADDR_W-1:0] pc_addr;
  logic                   flush;
  logic                   imem_ce;
  logic [INST_ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0]      imem_rdata;
  logic                   id_ready;
  logic                   id_valid;
  logic [INST_ADDR_W-1:0] id_pc;
  logic [INST_W-1:0]      id_inst;
  logic                   fetch_stall;
  logic [CNT_W-1:0]       occupancy;

  modport slave (
    input  ce, pc_addr, flush, imem_rdata, id_ready,
    output imem_ce, imem_addr, id_valid, id_pc, id_inst, fetch_stall, occupancy
  );

  modport master (
    output ce, pc_addr, flush, imem_rdata, id_ready,
    input  imem_ce, imem_addr, id_valid, id_pc, id_inst, fetch_stall, occupancy
  );

endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous {pc,inst} FIFO with synchronous flush; head is read straight from storage at rd_ptr.
module if_fetch_queue_fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     wdata,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

  no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/if_fetch_queue.sv
// IF back end: issues pc_addr to sync imem, pairs the returned word with its PC and queues it for ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input logic             clk,
  input logic             rst,
  if_fetch_queue_if.slave bus
);

  logic                   req_valid;
  logic [INST_ADDR_W-1:0] req_pc;
  logic                   stall;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   valid;
  logic [CNT_W-1:0]       count;
  fetch_entry_t           head;
  fetch_entry_t           wdata;

  // Counting the in-flight request reserves its slot, so a response can always be pushed.
  assign stall = (count + CNT_W'(req_valid)) >= CNT_W'(DEPTH);
  assign issue = bus.ce & ~bus.flush & ~stall;

  assign bus.fetch_stall = stall;
  assign bus.imem_ce     = issue;
  assign bus.imem_addr   = bus.pc_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else begin
      req_valid <= issue;
      if (issue) req_pc <= bus.pc_addr;
    end
  end

  assign push  = req_valid & ~bus.flush;
  assign valid = (count != '0);
  assign pop   = valid & bus.id_ready;
  assign wdata = '{pc: req_pc, inst: bus.imem_rdata};

  if_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign bus.id_valid  = valid;
  assign bus.id_pc     = valid ? head.pc   : ZERO_WORD;
  assign bus.id_inst   = valid ? head.inst : ZERO_WORD;
  assign bus.occupancy = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.CNT_W(3)) bus ();

  if_fetch_queue #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: entries queued for ID plus at most one outstanding memory request.
  fetch_entry_t   mq[$];
  bit             m_pend = 1'b0;
  logic [31:0]    m_pend_pc = '0;
  bit             auto_pc = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h0000_A000;
  endfunction

  function automatic bit exp_stall();
    return (mq.size() + int'(m_pend)) >= DEPTH;
  endfunction

  function automatic logic [2:0] exp_occ();
    return 3'(mq.size());
  endfunction

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return (mq.size() != 0) ? mq[0].inst : 32'h0;
  endfunction

  // One clock: emulate the synchronous imem, advance the model, step the PC if a fetch issued.
  task automatic tick();
    logic        dut_ce;
    logic [31:0] dut_addr;
    bit          iss;
    fetch_entry_t e;
    @(negedge clk);
    dut_ce   = bus.imem_ce;
    dut_addr = bus.imem_addr;
    iss      = bus.ce && !bus.flush && !exp_stall();
    @(posedge clk);
    #1;
    if (dut_ce === 1'b1) bus.imem_rdata = mem_word(dut_addr);
    if (rst) begin
      mq.delete();
      m_pend    = 1'b0;
      m_pend_pc = '0;
    end else if (bus.flush) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (mq.size() != 0 && bus.id_ready) void'(mq.pop_front());
      if (m_pend) begin
        e.pc   = m_pend_pc;
        e.inst = mem_word(m_pend_pc);
        mq.push_back(e);
      end
      m_pend = iss;
      if (iss) m_pend_pc = bus.pc_addr;
    end
    if (auto_pc && iss && !rst) bus.pc_addr = bus.pc_addr + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.pc_addr = '0;
    auto_pc = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.pc_addr = '0;
    bus.imem_rdata = '0;
    repeat (3) tick();
    checks += 6;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset id_valid: got %b want 0", bus.id_valid); end
    if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset id_pc: got %h want 0", bus.id_pc); end
    if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL reset id_inst: got %h want 0", bus.id_inst); end
    if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL reset fetch_stall: got %b want 0", bus.fetch_stall); end
    if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL reset occupancy: got %0d want 0", bus.occupancy); end
    if (bus.imem_ce !== 1'b0) begin errors++; $display("FAIL reset imem_ce: got %b want 0", bus.imem_ce); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    bus.ce = 1'b1;
    bus.id_ready = 1'b1;
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stream early id_valid: got %b want 0", bus.id_valid); end
    tick();
    checks += 3;
    if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL stream first id_valid: got %b want 1", bus.id_valid); end
    if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL stream first id_pc: got %h want 0", bus.id_pc); end
    if (bus.id_inst !== 32'hA000) begin errors++; $display("FAIL stream first id_inst: got %h want a000", bus.id_inst); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks += 3;
      if (bus.id_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream id_pc[%0d]: got %h want %h", k, bus.id_pc, 4 * k); end
      if (bus.id_inst !== mem_word(32'(4 * k))) begin errors++; $display("FAIL stream id_inst[%0d]: got %h want %h", k, bus.id_inst, mem_word(32'(4 * k))); end
      if (bus.occupancy !== 3'd1) begin errors++; $display("FAIL stream occupancy[%0d]: got %0d want 1", k, bus.occupancy); end
    end
  endtask

  task automatic test_backpressure();
    int occ_tab[6]   = '{0, 1, 2, 3, 4, 4};
    int stall_tab[6] = '{0, 0, 0, 1, 1, 1};
    do_reset();
    bus.ce = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks += 2;
      if (bus.occupancy !== 3'(occ_tab[k])) begin errors++; $display("FAIL bp occupancy[%0d]: got %0d want %0d", k, bus.occupancy, occ_tab[k]); end
      if (bus.fetch_stall !== 1'(stall_tab[k])) begin errors++; $display("FAIL bp fetch_stall[%0d]: got %b want %0d", k, bus.fetch_stall, stall_tab[k]); end
    end
    repeat (2) tick();
    checks += 3;
    if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL bp held id_pc: got %h want 0", bus.id_pc); end
    if (bus.id_inst !== 32'hA000) begin errors++; $display("FAIL bp held id_inst: got %h want a000", bus.id_inst); end
    if (bus.occupancy !== 3'd4) begin errors++; $display("FAIL bp held occupancy: got %0d want 4", bus.occupancy); end
    bus.ce = 1'b0;
    bus.id_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (bus.id_pc !== 32'(4 * k)) begin errors++; $display("FAIL bp drain id_pc[%0d]: got %h want %h", k, bus.id_pc, 4 * k); end
    end
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL bp drained id_valid: got %b want 0", bus.id_valid); end
  endtask

  task automatic test_full_pushpop();
    int          steady = 0;
    logic [2:0]  prev_occ;
    logic [31:0] last_pc;
    do_reset();
    bus.ce = 1'b1;
    repeat (6) tick();
    bus.id_ready = 1'b1;
    last_pc = bus.id_pc;
    for (int k = 0; k < 12; k++) begin
      prev_occ = bus.occupancy;
      tick();
      checks += 2;
      if (bus.occupancy !== exp_occ()) begin errors++; $display("FAIL full occupancy[%0d]: got %0d want %0d", k, bus.occupancy, exp_occ()); end
      if (bus.id_pc !== last_pc + 32'd4) begin errors++; $display("FAIL full order[%0d]: got %h want %h", k, bus.id_pc, last_pc + 32'd4); end
      if (bus.occupancy == prev_occ && prev_occ != 3'd0) steady++;
      last_pc = bus.id_pc;
    end
    checks++;
    if (steady == 0) begin errors++; $display("FAIL full push_pop_steady: got %0d cycles want >0", steady); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.ce = 1'b1;
    bus.id_ready = 1'b1;
    repeat (4) tick();
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.imem_ce !== 1'b0) begin errors++; $display("FAIL flush imem_ce: got %b want 0", bus.imem_ce); end
    tick();
    checks += 2;
    if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL flush occupancy: got %0d want 0", bus.occupancy); end
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush id_valid: got %b want 0", bus.id_valid); end
    bus.flush = 1'b0;
    bus.pc_addr = 32'h40;
    tick();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush stale entry: got valid %b pc %h want 0", bus.id_valid, bus.id_pc); end
    tick();
    checks += 3;
    if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL flush target id_valid: got %b want 1", bus.id_valid); end
    if (bus.id_pc !== 32'h40) begin errors++; $display("FAIL flush target id_pc: got %h want 40", bus.id_pc); end
    if (bus.id_inst !== 32'hA040) begin errors++; $display("FAIL flush target id_inst: got %h want a040", bus.id_inst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ce = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.occupancy !== 3'd3) begin errors++; $display("FAIL rstmid pre occupancy: got %0d want 3", bus.occupancy); end
    rst = 1'b1;
    bus.flush = 1'b1;
    bus.ce = 1'b0;
    tick();
    checks += 5;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rstmid id_valid: got %b want 0", bus.id_valid); end
    if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL rstmid id_pc: got %h want 0", bus.id_pc); end
    if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL rstmid id_inst: got %h want 0", bus.id_inst); end
    if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL rstmid occupancy: got %0d want 0", bus.occupancy); end
    if (bus.fetch_stall !== 1'b0) begin errors++; $display("FAIL rstmid fetch_stall: got %b want 0", bus.fetch_stall); end
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b1;
    repeat (2) tick();
    checks += 2;
    if (bus.occupancy !== 3'd0) begin errors++; $display("FAIL rstmid stale occupancy: got %0d want 0", bus.occupancy); end
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rstmid stale id_valid: got %b want 0", bus.id_valid); end
  endtask

  task automatic test_ce_toggle();
    do_reset();
    bus.pc_addr = 32'h100;
    bus.ce = 1'b1;
    tick();
    bus.ce = 1'b0;
    #1;
    checks++;
    if (bus.imem_ce !== 1'b0) begin errors++; $display("FAIL ce imem_ce while low: got %b want 0", bus.imem_ce); end
    tick();
    checks += 3;
    if (bus.occupancy !== 3'd1) begin errors++; $display("FAIL ce inflight occupancy: got %0d want 1", bus.occupancy); end
    if (bus.id_pc !== 32'h100) begin errors++; $display("FAIL ce inflight id_pc: got %h want 100", bus.id_pc); end
    if (bus.id_inst !== 32'hA100) begin errors++; $display("FAIL ce inflight id_inst: got %h want a100", bus.id_inst); end
    tick();
    checks++;
    if (bus.occupancy !== 3'd1) begin errors++; $display("FAIL ce idle occupancy: got %0d want 1", bus.occupancy); end
    bus.ce = 1'b1;
    tick();
    bus.ce = 1'b0;
    tick();
    checks++;
    if (bus.occupancy !== 3'd2) begin errors++; $display("FAIL ce resume occupancy: got %0d want 2", bus.occupancy); end
  endtask

  task automatic test_random();
    bit redirect = 1'b0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 99) < 2);
      bus.flush    = ($urandom_range(0, 99) < 8);
      bus.ce       = ($urandom_range(0, 99) < 80);
      bus.id_ready = ($urandom_range(0, 99) < 60);
      if (redirect) bus.pc_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      redirect = rst || bus.flush;
      #1;
      checks += 2;
      if (bus.imem_ce !== (bus.ce && !bus.flush && !exp_stall())) begin errors++; $display("FAIL rand imem_ce[%0d]: got %b want %b", k, bus.imem_ce, bus.ce && !bus.flush && !exp_stall()); end
      if (bus.imem_addr !== bus.pc_addr) begin errors++; $display("FAIL rand imem_addr[%0d]: got %h want %h", k, bus.imem_addr, bus.pc_addr); end
      tick();
      checks += 5;
      if (bus.id_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand id_valid[%0d]: got %b want %b", k, bus.id_valid, mq.size() != 0); end
      if (bus.id_pc !== exp_pc()) begin errors++; $display("FAIL rand id_pc[%0d]: got %h want %h", k, bus.id_pc, exp_pc()); end
      if (bus.id_inst !== exp_inst()) begin errors++; $display("FAIL rand id_inst[%0d]: got %h want %h", k, bus.id_inst, exp_inst()); end
      if (bus.occupancy !== exp_occ()) begin errors++; $display("FAIL rand occupancy[%0d]: got %0d want %0d", k, bus.occupancy, exp_occ()); end
      if (bus.fetch_stall !== exp_stall()) begin errors++; $display("FAIL rand fetch_stall[%0d]: got %b want %b", k, bus.fetch_stall, exp_stall()); end
    end
    rst = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.ce = 1'b0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    bus.pc_addr = '0;
    bus.imem_rdata = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
    test_ce_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
